// File: rtl/mem_wb_stage.sv
// Y86-style memory access stage plus MEM/WB register and processor status FSM.
// Latency 1 cycle. stall holds every output and blocks memory writes. Build option MEM_BOUNDS_CHECK_EN.
// Without MEM_BOUNDS_CHECK_EN there are no address errors; the word index wraps modulo the memory depth.
module mem_wb_stage #(
    parameter int DMEM_AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_icode_i,
    input  logic [31:0] mem_valA_i,
    input  logic [31:0] mem_valE_i,
    input  logic [31:0] mem_valP_i,
    input  logic [7:0]  mem_dstE_i,
    input  logic [7:0]  mem_dstM_i,
    input  logic        stall_i,
    output logic [7:0]  wb_icode_o,
    output logic [7:0]  wb_dstE_o,
    output logic [7:0]  wb_dstM_o,
    output logic [31:0] wb_valE_o,
    output logic [31:0] wb_valM_o,
    output logic [1:0]  stat_o
);
    localparam int DEPTH = 1 << DMEM_AW;
    localparam logic [7:0] RNONE = 8'h0F;

    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_ADR = 2'd2,
        S_INS = 2'd3
    } stat_e;

    stat_e state_q, state_d;

    logic [31:0] mem [DEPTH];

    logic [3:0]         op;
    logic               is_wr, is_rd, addr_from_a, ins_err, hlt, adr_err, we;
    logic [31:0]        wdata, rdata;
    logic [DMEM_AW-1:0] idx;

    logic [7:0]  icode_d, dste_d, dstm_d;
    logic [31:0] vale_d, valm_d;

    assign op          = mem_icode_i[3:0];
    assign is_wr       = (op == 4'h4) || (op == 4'hA) || (op == 4'h8);
    assign is_rd       = (op == 4'h5) || (op == 4'hB) || (op == 4'h9);
    assign addr_from_a = (op == 4'hB) || (op == 4'h9);
    assign wdata       = (op == 4'h8) ? mem_valP_i : mem_valA_i;
    assign ins_err     = (op > 4'hB);
    assign hlt         = (op == 4'h0);

`ifdef MEM_BOUNDS_CHECK_EN
    logic [31:0] addr;
    assign addr    = addr_from_a ? mem_valA_i : mem_valE_i;
    assign idx     = addr[DMEM_AW+1:2];
    assign adr_err = (is_rd || is_wr) && ((addr[1:0] != 2'b00) || (addr[31:DMEM_AW+2] != '0));
`else
    assign idx     = addr_from_a ? mem_valA_i[DMEM_AW+1:2] : mem_valE_i[DMEM_AW+1:2];
    assign adr_err = 1'b0;
`endif

    assign rdata = mem[idx];

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        icode_d = wb_icode_o;
        dste_d  = wb_dstE_o;
        dstm_d  = wb_dstM_o;
        vale_d  = wb_valE_o;
        valm_d  = wb_valM_o;
        if (!stall_i) begin
            if (state_q != S_AOK) begin
                icode_d = 8'h01;
                dste_d  = RNONE;
                dstm_d  = RNONE;
                vale_d  = '0;
                valm_d  = '0;
            end else begin
                icode_d = mem_icode_i;
                dste_d  = mem_dstE_i;
                dstm_d  = mem_dstM_i;
                vale_d  = mem_valE_i;
                valm_d  = is_rd ? rdata : '0;
                // INS outranks ADR; halt never accesses memory so it cannot collide with ADR
                if (ins_err)      state_d = S_INS;
                else if (adr_err) state_d = S_ADR;
                else if (hlt)     state_d = S_HLT;
                if (state_d != S_AOK) begin
                    dste_d = RNONE;
                    dstm_d = RNONE;
                end else begin
                    we = is_wr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_AOK;
            wb_icode_o <= 8'h01;
            wb_dstE_o  <= RNONE;
            wb_dstM_o  <= RNONE;
            wb_valE_o  <= '0;
            wb_valM_o  <= '0;
        end else begin
            state_q    <= state_d;
            wb_icode_o <= icode_d;
            wb_dstE_o  <= dste_d;
            wb_dstM_o  <= dstm_d;
            wb_valE_o  <= vale_d;
            wb_valM_o  <= valm_d;
        end
    end

    // Memory contents are not reset; a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (we && !rst) mem[idx] <= wdata;
    end

    assign stat_o = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against an instruction-level reference model.
module tb_mem_wb_stage;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst;
    logic [7:0]  icode, dste, dstm;
    logic [31:0] vala, vale, valp;
    logic        stall;
    logic [7:0]  wb_icode, wb_dste, wb_dstm;
    logic [31:0] wb_vale, wb_valm;
    logic [1:0]  stat;

    mem_wb_stage #(.DMEM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_icode_i(icode), .mem_valA_i(vala), .mem_valE_i(vale), .mem_valP_i(valp),
        .mem_dstE_i(dste), .mem_dstM_i(dstm), .stall_i(stall),
        .wb_icode_o(wb_icode), .wb_dstE_o(wb_dste), .wb_dstM_o(wb_dstm),
        .wb_valE_o(wb_vale), .wb_valM_o(wb_valm), .stat_o(stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdl_mem [DEPTH];
    int          st;
    logic [7:0]  e_icode, e_dste, e_dstm;
    logic [31:0] e_vale, e_valm;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction-level model: what each instruction does to memory, status and WB.
    task automatic model(input logic r, input logic s, input logic [7:0] ic,
                         input logic [31:0] a, input logic [31:0] e, input logic [31:0] p,
                         input logic [7:0] de, input logic [7:0] dm);
        int n, w;
        bit wr, rd, bad;
        logic [31:0] ad;
        if (r) begin
            st = 0; e_icode = 8'h01; e_dste = 8'h0F; e_dstm = 8'h0F; e_vale = 0; e_valm = 0;
        end else if (!s) begin
            if (st != 0) begin
                e_icode = 8'h01; e_dste = 8'h0F; e_dstm = 8'h0F; e_vale = 0; e_valm = 0;
            end else begin
                n   = int'(ic) % 16;
                wr  = (n == 4) || (n == 10) || (n == 8);
                rd  = (n == 5) || (n == 11) || (n == 9);
                ad  = (n == 11 || n == 9) ? a : e;
                w   = int'((ad / 4) % DEPTH);
                bad = 0;
`ifdef MEM_BOUNDS_CHECK_EN
                bad = (wr || rd) && ((ad % 4) != 0 || longint'(ad) >= longint'(4 * DEPTH));
`endif
                e_icode = ic; e_vale = e; e_dste = de; e_dstm = dm;
                e_valm  = rd ? mdl_mem[w] : 32'd0;
                if (n > 11)      st = 3;
                else if (bad)    st = 2;
                else if (n == 0) st = 1;
                if (st != 0) begin
                    e_dste = 8'h0F; e_dstm = 8'h0F;
                end else if (wr) begin
                    mdl_mem[w] = (n == 8) ? p : a;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [7:0] ic,
                        input logic [31:0] a, input logic [31:0] e, input logic [31:0] p,
                        input logic [7:0] de, input logic [7:0] dm);
        rst = r; stall = s; icode = ic; vala = a; vale = e; valp = p; dste = de; dstm = dm;
        @(posedge clk);
        model(r, s, ic, a, e, p, de, dm);
        #1;
        chk("wb_icode", {24'd0, wb_icode}, {24'd0, e_icode});
        chk("wb_dstE",  {24'd0, wb_dste},  {24'd0, e_dste});
        chk("wb_dstM",  {24'd0, wb_dstm},  {24'd0, e_dstm});
        chk("wb_valE",  wb_vale, e_vale);
        chk("wb_valM",  wb_valm, e_valm);
        chk("stat",     {30'd0, stat}, 32'(st));
    endtask

    initial begin
        logic [3:0]  ops [10];
        logic [3:0]  n;
        logic [7:0]  ic;
        logic [31:0] addr, data;
        ops = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        st = 0;
        rst = 1; stall = 0; icode = 8'h01; vala = 0; vale = 0; valp = 0; dste = 8'h0F; dstm = 8'h0F;

        // reset state
        step(1, 0, 8'h01, 0, 0, 0, 8'h0F, 8'h0F);
        step(1, 1, 8'h05, 0, 32'h10, 0, 8'h01, 8'h02);
        chk("reset_icode", {24'd0, wb_icode}, 32'h01);

        // preload every word so later reads are fully predictable
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 8'h04, $urandom, 32'(i * 4), 0, 8'h0F, 8'h0F);

        // rmmovl then mrmovl of the same word
        step(0, 0, 8'h04, 32'hDEADBEEF, 32'h10, 0, 8'h0F, 8'h0F);
        step(0, 0, 8'h05, 0, 32'h10, 0, 8'h0F, 8'h03);
        chk("rmmov_mrmov_valM", wb_valm, 32'hDEADBEEF);
        chk("rmmov_mrmov_dstM", {24'd0, wb_dstm}, 32'h3);

        // pushl/popl and call/ret pairs
        step(0, 0, 8'h0A, 32'h7, 32'h3C, 0, 8'h04, 8'h0F);
        step(0, 0, 8'h0B, 32'h3C, 32'h40, 0, 8'h04, 8'h02);
        chk("push_pop_valM", wb_valm, 32'h7);
        step(0, 0, 8'h08, 0, 32'h38, 32'h20, 8'h04, 8'h0F);
        step(0, 0, 8'h09, 32'h38, 32'h3C, 0, 8'h04, 8'h0F);
        chk("call_ret_valM", wb_valm, 32'h20);

        // stall: mrmovl held for three cycles, then released; a stalled write is dropped
        step(0, 0, 8'h04, 32'h55AA1234, 32'h10, 0, 8'h0F, 8'h0F);
        step(0, 1, 8'h04, 32'h0BADF00D, 32'h10, 0, 8'h0F, 8'h0F);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h05, 0, 32'h10, 0, 8'h0F, 8'h06);
        chk("stall_hold_icode", {24'd0, wb_icode}, 32'h04);
        step(0, 0, 8'h05, 0, 32'h10, 0, 8'h0F, 8'h06);
        chk("stall_release_valM", wb_valm, 32'h55AA1234);

        // reset in the cycle of a write discards it
        step(1, 0, 8'h04, 32'h12345678, 32'h4, 0, 8'h02, 8'h0F);
        step(0, 0, 8'h05, 0, 32'h4, 0, 8'h0F, 8'h01);

        // randomized instruction mix with random stalls
        for (int k = 0; k < 400; k++) begin
            n    = ops[$urandom_range(0, 9)];
            ic   = {4'($urandom_range(0, 15)), n};
            addr = 32'($urandom_range(0, DEPTH - 1) * 4);
`ifndef MEM_BOUNDS_CHECK_EN
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FC03);
`endif
            data = $urandom;
            if (n == 4'hB || n == 4'h9)
                step(0, ($urandom_range(0, 4) == 0), ic, addr, $urandom, $urandom,
                     8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            else
                step(0, ($urandom_range(0, 4) == 0), ic, data, addr, $urandom,
                     8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
        end

        // out-of-range address: ADR with bounds checking, wrap to word 0 without
        step(0, 0, 8'h04, 32'hCAFEF00D, 32'h402, 0, 8'h0F, 8'h0F);
`ifdef MEM_BOUNDS_CHECK_EN
        chk("oob_stat_adr", {30'd0, stat}, 32'd2);
        step(1, 0, 8'h01, 0, 0, 0, 8'h0F, 8'h0F);
        step(0, 0, 8'h05, 0, 32'h0, 0, 8'h0F, 8'h01);
`else
        step(0, 0, 8'h05, 0, 32'h0, 0, 8'h0F, 8'h01);
        chk("oob_wrap_valM", wb_valm, 32'hCAFEF00D);
`endif

        // halt: status sticks, later write suppressed, bubbles until reset
        step(0, 0, 8'h00, 0, 32'h44, 0, 8'h03, 8'h04);
        chk("halt_stat", {30'd0, stat}, 32'd1);
        step(0, 0, 8'h04, 32'hFEEDFACE, 32'h20, 0, 8'h02, 8'h0F);
        chk("halt_bubble_icode", {24'd0, wb_icode}, 32'h01);
        step(0, 1, 8'h04, 32'hFEEDFACE, 32'h20, 0, 8'h02, 8'h0F);
        step(0, 0, 8'h05, 0, 32'h20, 0, 8'h02, 8'h01);
        step(1, 0, 8'h01, 0, 0, 0, 8'h0F, 8'h0F);
        step(0, 0, 8'h05, 0, 32'h20, 0, 8'h0F, 8'h01);

        // invalid icode
        step(0, 0, 8'h0C, 32'h1, 32'h2, 0, 8'h05, 8'h06);
        chk("ins_stat", {30'd0, stat}, 32'd3);
        step(0, 0, 8'h04, 32'h99, 32'h8, 0, 8'h0F, 8'h0F);
        step(1, 0, 8'h01, 0, 0, 0, 8'h0F, 8'h0F);
        step(0, 0, 8'h05, 0, 32'h8, 0, 8'h0F, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
